// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// Inputs (datapath -> controller):
//   idex_memread_i, idex_rt_i    load flag and destination register in ID/EX
//   ifid_rs_i, ifid_rt_i         source registers in IF/ID
//   branch_taken_i               branch resolved taken in ID
//   dmem_stall_i                 data memory not ready
// Outputs (controller -> datapath):
//   pc_write_o, ifid_write_o     PC and IF/ID write enables
//   ifid_flush_o, idex_bubble_o  zero IF/ID / load a NOP into ID/EX
//   freeze_o                     hold ID/EX, EX/MEM and MEM/WB
//   fault_o                      sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o     saturating performance counters
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             branch_taken_i;
  logic             dmem_stall_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             freeze_o;
  logic             fault_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, dmem_stall_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           freeze_o, fault_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, dmem_stall_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           freeze_o, fault_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory
// freeze with timeout fault, and saturating stall/flush counters.
// Ports:
//   clk_i  single clock, rising edge
//   rst_i  synchronous active-high reset
//   hz     pipeline_hazard_ctrl_if slave modport (see interface header)
// Parameters:
//   CNT_W        width of stall/flush counters (must match hz CNT_W)
//   MEM_TIMEOUT  consecutive dmem stall cycles before entering FAULT
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  state_e dec_state;
  logic   load_use;

  assign load_use = hz.idex_memread_i && (hz.idex_rt_i != 5'd0) &&
                    ((hz.idex_rt_i == hz.ifid_rs_i) ||
                     (hz.idex_rt_i == hz.ifid_rt_i));

  // While reset is held the outputs decode as RUN, whatever the stored state.
  assign dec_state = rst_i ? RUN : state_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (hz.dmem_stall_i) begin
          // wait_cnt_q is 0 in RUN, so the same compare covers entry
          // from RUN and continuation in MEM_WAIT.
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) state_d = FAULT;
          else                                        state_d = MEM_WAIT;
        end else begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end
      end
      FAULT:   state_d = FAULT;
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    hz.pc_write_o    = 1'b1;
    hz.ifid_write_o  = 1'b1;
    hz.ifid_flush_o  = 1'b0;
    hz.idex_bubble_o = 1'b0;
    hz.freeze_o      = 1'b0;
    if (dec_state == FAULT) begin
      hz.pc_write_o   = 1'b0;
      hz.ifid_write_o = 1'b0;
      hz.freeze_o     = 1'b1;
    end else if (hz.dmem_stall_i) begin
      // Frozen IF/ID keeps any pending branch until the stall clears.
      hz.pc_write_o   = 1'b0;
      hz.ifid_write_o = 1'b0;
      hz.freeze_o     = 1'b1;
    end else if (load_use) begin
      hz.pc_write_o    = 1'b0;
      hz.ifid_write_o  = 1'b0;
      hz.idex_bubble_o = 1'b1;
    end else if (hz.branch_taken_i) begin
      hz.ifid_flush_o = 1'b1;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hz.pc_write_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (hz.ifid_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign hz.fault_o     = (state_q == FAULT);
  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: instance A uses defaults,
// instance B uses CNT_W=3, MEM_TIMEOUT=4. Both share the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       memread, br, stall;
  logic [4:0] rt, rs, rtt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) ia ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  ib ();

  assign ia.idex_memread_i = memread;
  assign ia.idex_rt_i      = rt;
  assign ia.ifid_rs_i      = rs;
  assign ia.ifid_rt_i      = rtt;
  assign ia.branch_taken_i = br;
  assign ia.dmem_stall_i   = stall;
  assign ib.idex_memread_i = memread;
  assign ib.idex_rt_i      = rt;
  assign ib.ifid_rs_i      = rs;
  assign ib.ifid_rt_i      = rtt;
  assign ib.branch_taken_i = br;
  assign ib.dmem_stall_i   = stall;

  pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (ia.slave)
  );

  pipeline_hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (ib.slave)
  );

  typedef struct {
    logic       memread;
    logic [4:0] rt, rs, rtt;
    logic       br, stall;
    logic       pc_w, ifid_w, flush, bubble, freeze;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic b, input logic st);
    memread = m; rt = d; rs = s1; rtt = s2; br = b; stall = st;
  endtask

  // Call at posedge+1; leaves the bench at the next posedge+1 with rst low.
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_ctrl_a(input string nm, input logic pw, input logic iw,
                            input logic fl, input logic bu, input logic fr);
    chk({nm, ".pc_write"},    ia.pc_write_o,    pw);
    chk({nm, ".ifid_write"},  ia.ifid_write_o,  iw);
    chk({nm, ".ifid_flush"},  ia.ifid_flush_o,  fl);
    chk({nm, ".idex_bubble"}, ia.idex_bubble_o, bu);
    chk({nm, ".freeze"},      ia.freeze_o,      fr);
  endtask

  int exp_stall, exp_flush;

  initial begin
    //          mr rt  rs  rtt br st  pc iw fl bu fr
    vecs[0]  = '{0, 5,  5,  0,  0, 0, 1, 1, 0, 0, 0};  // normal, no load
    vecs[1]  = '{1, 5,  5,  0,  0, 0, 0, 0, 0, 1, 0};  // LU on rs
    vecs[2]  = '{1, 7,  1,  7,  0, 0, 0, 0, 0, 1, 0};  // LU on rt
    vecs[3]  = '{1, 0,  0,  0,  0, 0, 1, 1, 0, 0, 0};  // r0 never hazards
    vecs[4]  = '{1, 3,  4,  6,  0, 0, 1, 1, 0, 0, 0};  // load, no match
    vecs[5]  = '{0, 0,  0,  0,  1, 0, 1, 1, 1, 0, 0};  // branch flush
    vecs[6]  = '{1, 5,  5,  0,  1, 0, 0, 0, 0, 1, 0};  // LU beats branch
    vecs[7]  = '{1, 5,  5,  0,  1, 1, 0, 0, 0, 0, 1};  // stall beats all
    vecs[8]  = '{0, 0,  0,  0,  0, 1, 0, 0, 0, 0, 1};  // stall alone
    vecs[9]  = '{0, 0,  0,  0,  1, 0, 1, 1, 1, 0, 0};  // leave MEM_WAIT w/ branch
    vecs[10] = '{0, 2,  3,  4,  0, 0, 1, 1, 0, 0, 0};  // normal

    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    chk("reset.stall_cnt", ia.stall_cnt_o, 0);
    chk("reset.flush_cnt", ia.flush_cnt_o, 0);
    chk("reset.fault",     ia.fault_o,     0);
    chk_ctrl_a("reset", 1, 1, 0, 0, 0);

    // Table-driven combinational decode
    exp_stall = 0;
    exp_flush = 0;
    for (int unsigned i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].memread, vecs[i].rt, vecs[i].rs, vecs[i].rtt, vecs[i].br, vecs[i].stall);
      #3;
      chk_ctrl_a($sformatf("vec%0d", i), vecs[i].pc_w, vecs[i].ifid_w,
                 vecs[i].flush, vecs[i].bubble, vecs[i].freeze);
      if (!vecs[i].pc_w) exp_stall++;
      if (vecs[i].flush) exp_flush++;
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("table.stall_cnt", ia.stall_cnt_o, exp_stall);
    chk("table.flush_cnt", ia.flush_cnt_o, exp_flush);

    // Single load-use cycle counts one stall
    do_reset();
    drive(1, 5, 5, 0, 0, 0);
    #3;
    chk("lu1.stall_cnt_before", ia.stall_cnt_o, 0);
    chk_ctrl_a("lu1", 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("lu1.stall_cnt_after", ia.stall_cnt_o, 1);

    // LU+branch then branch only: bubble, then flush
    do_reset();
    drive(1, 5, 5, 0, 1, 0);
    #3;
    chk_ctrl_a("lubr.c1", 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0);
    #3;
    chk_ctrl_a("lubr.c2", 1, 1, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("lubr.flush_cnt", ia.flush_cnt_o, 1);
    chk("lubr.stall_cnt", ia.stall_cnt_o, 1);

    // 10-cycle dmem stall on default instance
    do_reset();
    for (int unsigned k = 0; k < 10; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      #3;
      chk($sformatf("stall10.c%0d.freeze", k + 1), ia.freeze_o, 1);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk_ctrl_a("stall10.c11", 1, 1, 0, 0, 0);
    chk("stall10.stall_cnt", ia.stall_cnt_o, 10);
    chk("stall10.fault",     ia.fault_o,     0);

    // Reset during MEM_WAIT shows RUN decoding, then RUN after the edge
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 5, 5, 0, 0, 0);
    #3;
    chk_ctrl_a("rst_memwait", 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    #3;
    chk_ctrl_a("rst_memwait.after", 1, 1, 1, 0, 0);
    chk("rst_memwait.stall_cnt", ia.stall_cnt_o, 0);

    // Timeout fault on instance B (MEM_TIMEOUT=4)
    @(posedge clk); #1;
    do_reset();
    for (int unsigned k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      #3;
      chk($sformatf("tmo.c%0d.fault", k), ib.fault_o, (k >= 5) ? 1 : 0);
      @(posedge clk); #1;
    end
    for (int unsigned k = 0; k < 3; k++) begin
      drive(1, 5, 5, 0, 1, 0);
      #3;
      chk($sformatf("tmo.hold%0d.fault", k), ib.fault_o, 1);
      chk($sformatf("tmo.hold%0d.pc_write", k), ib.pc_write_o, 0);
      chk($sformatf("tmo.hold%0d.freeze", k), ib.freeze_o, 1);
      chk($sformatf("tmo.hold%0d.bubble", k), ib.idex_bubble_o, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("tmo.rst.pc_write", ib.pc_write_o, 1);
    chk("tmo.rst.freeze",   ib.freeze_o,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    chk("tmo.after.fault",     ib.fault_o,     0);
    chk("tmo.after.stall_cnt", ib.stall_cnt_o, 0);
    chk("tmo.after.flush_cnt", ib.flush_cnt_o, 0);

    // Saturation on CNT_W=3
    @(posedge clk); #1;
    do_reset();
    for (int unsigned k = 1; k <= 9; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      #3;
      if (k == 7) chk("sat.after6", ib.stall_cnt_o, 6);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("sat.after9", ib.stall_cnt_o, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall and flush performance counters.
REQ-002 Parameter MEM_TIMEOUT, default 64, number of consecutive dmem stall cycles before the block declares a fault.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 idex_memread_i  input  1  the instruction in ID/EX is a load.
REQ-006 idex_rt_i  input  5  destination register of the ID/EX instruction.
REQ-007 ifid_rs_i, ifid_rt_i  input  5 each  source registers of the IF/ID instruction.
REQ-008 branch_taken_i  input  1  the branch resolved in ID is taken.
REQ-009 dmem_stall_i  input  1  data memory not ready; pipeline must hold.
REQ-010 pc_write_o  output  1  PC register write enable.
REQ-011 ifid_write_o  output  1  IF/ID register write enable.
REQ-012 ifid_flush_o  output  1  zero the IF/ID register on the next edge.
REQ-013 idex_bubble_o  output  1  load a NOP into ID/EX on the next edge.
REQ-014 freeze_o  output  1  hold ID/EX, EX/MEM and MEM/WB registers.
REQ-015 fault_o  output  1  sticky memory-timeout flag.
REQ-016 stall_cnt_o  output  CNT_W  count of cycles with pc_write_o=0.
REQ-017 flush_cnt_o  output  CNT_W  count of cycles with ifid_flush_o=1.

Function
REQ-018 Load-use hazard (LU) SHALL be idex_memread_i=1 AND idex_rt_i!=0 AND (idex_rt_i==ifid_rs_i OR idex_rt_i==ifid_rt_i).
REQ-019 FSM states SHALL be RUN, MEM_WAIT and FAULT, encoded in a registered state.
REQ-020 Control outputs SHALL be combinational from the current state and inputs; there is no added latency.
REQ-021 Priority in RUN/MEM_WAIT SHALL be dmem_stall_i > LU > branch_taken_i > normal.
REQ-022 dmem_stall_i=1: pc_write_o=0, ifid_write_o=0, freeze_o=1, idex_bubble_o=0, ifid_flush_o=0.
REQ-023 LU without stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, freeze_o=0, ifid_flush_o=0; branch_taken_i is ignored that cycle.
REQ-024 branch_taken_i without stall or LU: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=0, freeze_o=0.
REQ-025 Normal: pc_write_o=1, ifid_write_o=1, all other control outputs 0.
REQ-026 RUN->MEM_WAIT when dmem_stall_i=1; MEM_WAIT->RUN on the edge where dmem_stall_i=0, and that cycle's outputs SHALL follow REQ-023..025.
REQ-027 An internal wait counter SHALL clear in RUN, count consecutive dmem_stall_i cycles, and move the FSM to FAULT when it reaches MEM_TIMEOUT.
REQ-028 FAULT SHALL be absorbing until reset: pc_write_o=0, ifid_write_o=0, freeze_o=1, fault_o=1, and all inputs are ignored.
REQ-029 A branch and a stall in the same cycle SHALL drop nothing, because the frozen IF/ID holds the branch until the stall clears.
REQ-030 stall_cnt_o SHALL increment by 1 each cycle pc_write_o=0, saturating at all-ones.
REQ-031 flush_cnt_o SHALL increment by 1 each cycle ifid_flush_o=1, saturating at all-ones.

Reset
REQ-032 rst_i=1 at a rising edge SHALL force the state to RUN, the wait counter to 0, fault_o=0, stall_cnt_o=0 and flush_cnt_o=0, overriding all other inputs.
REQ-033 While rst_i=1, control outputs SHALL show RUN decoding of the current inputs; reset during MEM_WAIT or FAULT SHALL return the block to RUN on the next edge.

Verification
REQ-034 idex_memread=1, idex_rt=5, ifid_rs=5 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_cnt goes 0->1.
REQ-035 idex_rt=0 with memread=1 and ifid_rs=0 -> no stall, pc_write=1.
REQ-036 LU and branch_taken together, then only branch_taken on the next cycle -> bubble on cycle 1, ifid_flush=1 on cycle 2, flush_cnt=1.
REQ-037 dmem_stall held 10 cycles -> freeze=1 for 10 cycles, stall_cnt=10, and RUN-mode outputs on cycle 11.
REQ-038 MEM_TIMEOUT=4 and dmem_stall held 6 cycles -> fault_o=1 after the 4th stall edge and stays 1 after the stall clears; rst_i pulse -> fault_o=0 with both counters at 0.
REQ-039 CNT_W=3 with 9 stall cycles -> stall_cnt saturates at 7.
